// File: rtl/w5300_udp_init_seq.sv
// W5300 power-up sequencer: MR reset, network/buffer config, socket open in UDP mode, Sn_SSR poll.
// Optional IDR check after reset is enabled by defining W5300_INIT_ID_CHECK_EN.
module w5300_udp_init_seq #(
    parameter int SOCKET_N        = 0,
    parameter int RST_WAIT_CYCLES = 1000,
    parameter int POLL_GAP_CYCLES = 64,
    parameter int POLL_MAX        = 16,
    parameter int TX_KB           = 8,
    parameter int RX_KB           = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [47:0] i_mac,
    input  logic [31:0] i_ip,
    input  logic [31:0] i_subnet,
    input  logic [15:0] i_src_port,
    output logic        o_reg_req,
    output logic        o_reg_wr,
    output logic [9:0]  o_reg_addr,
    output logic [15:0] o_reg_wdata,
    input  logic [15:0] i_reg_rdata,
    input  logic        i_reg_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [1:0]  o_error_code
);

    localparam int RW = $clog2(RST_WAIT_CYCLES + 1);
    localparam int GW = $clog2(POLL_GAP_CYCLES + 1);
    localparam int PW = $clog2(POLL_MAX + 1);

    localparam logic [9:0] SOCK_OFS  = 10'(SOCKET_N * 64);
    localparam logic [9:0] A_MR      = 10'h000;
    localparam logic [9:0] A_IMR     = 10'h004;
    localparam logic [9:0] A_SHAR0   = 10'h008;
    localparam logic [9:0] A_SHAR2   = 10'h00A;
    localparam logic [9:0] A_SHAR4   = 10'h00C;
    localparam logic [9:0] A_GAR0    = 10'h010;
    localparam logic [9:0] A_GAR2    = 10'h012;
    localparam logic [9:0] A_SUBR0   = 10'h014;
    localparam logic [9:0] A_SUBR2   = 10'h016;
    localparam logic [9:0] A_TMS01R  = 10'h020;
    localparam logic [9:0] A_RMS01R  = 10'h028;
    localparam logic [9:0] A_IDR     = 10'h0FE;
    localparam logic [9:0] A_SN_MR   = 10'h200 + SOCK_OFS;
    localparam logic [9:0] A_SN_CR   = 10'h202 + SOCK_OFS;
    localparam logic [9:0] A_SN_SSR  = 10'h208 + SOCK_OFS;
    localparam logic [9:0] A_SN_PORT = 10'h20A + SOCK_OFS;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_WR,
        S_RST_WAIT,
`ifdef W5300_INIT_ID_CHECK_EN
        S_ID_RD,
`endif
        S_CFG,
        S_POLL_RD,
        S_POLL_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_req, w_req_nxt;
    logic          r_wr, w_wr_nxt;
    logic [9:0]    r_addr, w_addr_nxt;
    logic [15:0]   r_wdata, w_wdata_nxt;
    logic [3:0]    r_step, w_step_nxt;
    logic [RW-1:0] r_rst_cnt, w_rst_cnt_nxt;
    logic [GW-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic [PW-1:0] r_poll_cnt, w_poll_cnt_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_error, w_error_nxt;
    logic [1:0]    r_code, w_code_nxt;
    logic [47:0]   r_mac, w_mac_nxt;
    logic [31:0]   r_ip, w_ip_nxt;
    logic [31:0]   r_subnet, w_subnet_nxt;
    logic [15:0]   r_port, w_port_nxt;
    logic [9:0]    w_cfg_addr;
    logic [15:0]   w_cfg_data;
    logic [PW-1:0] w_poll_inc;
    logic          w_acked;

    assign o_reg_req    = r_req;
    assign o_reg_wr     = r_wr;
    assign o_reg_addr   = r_addr;
    assign o_reg_wdata  = r_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_error_code = r_code;

    assign w_acked    = r_req & i_reg_ack;
    assign w_poll_inc = r_poll_cnt + {{(PW-1){1'b0}}, 1'b1};

    // Config write table indexed by the CFG step counter
    always_comb begin
        w_cfg_addr = 10'h000;
        w_cfg_data = 16'h0000;
        case (r_step)
            4'd0:    begin w_cfg_addr = A_SHAR0;   w_cfg_data = r_mac[47:32]; end
            4'd1:    begin w_cfg_addr = A_SHAR2;   w_cfg_data = r_mac[31:16]; end
            4'd2:    begin w_cfg_addr = A_SHAR4;   w_cfg_data = r_mac[15:0]; end
            4'd3:    begin w_cfg_addr = A_GAR0;    w_cfg_data = r_ip[31:16]; end
            4'd4:    begin w_cfg_addr = A_GAR2;    w_cfg_data = {r_ip[15:8], 8'h01}; end
            4'd5:    begin w_cfg_addr = A_SUBR0;   w_cfg_data = r_subnet[31:16]; end
            4'd6:    begin w_cfg_addr = A_SUBR2;   w_cfg_data = r_subnet[15:0]; end
            4'd7:    begin w_cfg_addr = A_TMS01R;  w_cfg_data = {8'(TX_KB), 8'd8}; end
            4'd8:    begin w_cfg_addr = A_RMS01R;  w_cfg_data = {8'(RX_KB), 8'd8}; end
            4'd9:    begin w_cfg_addr = A_IMR;     w_cfg_data = 16'h0000; end
            4'd10:   begin w_cfg_addr = A_SN_MR;   w_cfg_data = 16'h0002; end
            4'd11:   begin w_cfg_addr = A_SN_PORT; w_cfg_data = r_port; end
            4'd12:   begin w_cfg_addr = A_SN_CR;   w_cfg_data = 16'h0001; end
            default: begin w_cfg_addr = 10'h000;   w_cfg_data = 16'h0000; end
        endcase
    end

    // Next-state and next-output logic; an access is issued when the state is entered with req low
    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_wr_nxt       = r_wr;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_step_nxt     = r_step;
        w_rst_cnt_nxt  = r_rst_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_poll_cnt_nxt = r_poll_cnt;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_error_nxt    = r_error;
        w_code_nxt     = r_code;
        w_mac_nxt      = r_mac;
        w_ip_nxt       = r_ip;
        w_subnet_nxt   = r_subnet;
        w_port_nxt     = r_port;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_mac_nxt      = i_mac;
                    w_ip_nxt       = i_ip;
                    w_subnet_nxt   = i_subnet;
                    w_port_nxt     = i_src_port;
                    w_done_nxt     = 1'b0;
                    w_error_nxt    = 1'b0;
                    w_code_nxt     = 2'd0;
                    w_busy_nxt     = 1'b1;
                    w_step_nxt     = 4'd0;
                    w_poll_cnt_nxt = '0;
                    w_state_nxt    = S_RST_WR;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RST_WR: begin
                if (!r_req) begin
                    w_req_nxt   = 1'b1;
                    w_wr_nxt    = 1'b1;
                    w_addr_nxt  = A_MR;
                    w_wdata_nxt = 16'h0080;
                end else if (w_acked) begin
                    w_req_nxt     = 1'b0;
                    w_rst_cnt_nxt = '0;
                    w_state_nxt   = S_RST_WAIT;
                end else begin
                    w_req_nxt = 1'b1;
                end
            end
            // The first post-reset access is raised on the last wait cycle so the idle gap is exact
            S_RST_WAIT: begin
                if (r_rst_cnt == RW'(RST_WAIT_CYCLES - 1)) begin
                    w_req_nxt   = 1'b1;
`ifdef W5300_INIT_ID_CHECK_EN
                    w_wr_nxt    = 1'b0;
                    w_addr_nxt  = A_IDR;
                    w_wdata_nxt = 16'h0000;
                    w_state_nxt = S_ID_RD;
`else
                    w_wr_nxt    = 1'b1;
                    w_addr_nxt  = w_cfg_addr;
                    w_wdata_nxt = w_cfg_data;
                    w_state_nxt = S_CFG;
`endif
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + {{(RW-1){1'b0}}, 1'b1};
                end
            end
`ifdef W5300_INIT_ID_CHECK_EN
            S_ID_RD: begin
                if (!r_req) begin
                    w_req_nxt   = 1'b1;
                    w_wr_nxt    = 1'b0;
                    w_addr_nxt  = A_IDR;
                    w_wdata_nxt = 16'h0000;
                end else if (w_acked) begin
                    w_req_nxt = 1'b0;
                    if (i_reg_rdata == 16'h5300) begin
                        w_state_nxt = S_CFG;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_error_nxt = 1'b1;
                        w_code_nxt  = 2'd1;
                        w_state_nxt = S_ERROR;
                    end
                end else begin
                    w_req_nxt = 1'b1;
                end
            end
`endif
            S_CFG: begin
                if (!r_req) begin
                    w_req_nxt   = 1'b1;
                    w_wr_nxt    = 1'b1;
                    w_addr_nxt  = w_cfg_addr;
                    w_wdata_nxt = w_cfg_data;
                end else if (w_acked) begin
                    w_req_nxt = 1'b0;
                    if (r_step == 4'd12) begin
                        w_state_nxt = S_POLL_RD;
                    end else begin
                        w_step_nxt = r_step + 4'd1;
                    end
                end else begin
                    w_req_nxt = 1'b1;
                end
            end
            // Only the low byte of Sn_SSR carries the socket status
            S_POLL_RD: begin
                if (!r_req) begin
                    w_req_nxt   = 1'b1;
                    w_wr_nxt    = 1'b0;
                    w_addr_nxt  = A_SN_SSR;
                    w_wdata_nxt = 16'h0000;
                end else if (w_acked) begin
                    w_req_nxt = 1'b0;
                    if (i_reg_rdata[7:0] == 8'h22) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (w_poll_inc == PW'(POLL_MAX)) begin
                        w_poll_cnt_nxt = w_poll_inc;
                        w_busy_nxt     = 1'b0;
                        w_error_nxt    = 1'b1;
                        w_code_nxt     = 2'd2;
                        w_state_nxt    = S_ERROR;
                    end else begin
                        w_poll_cnt_nxt = w_poll_inc;
                        w_gap_cnt_nxt  = '0;
                        w_state_nxt    = S_POLL_GAP;
                    end
                end else begin
                    w_req_nxt = 1'b1;
                end
            end
            S_POLL_GAP: begin
                if (r_gap_cnt == GW'(POLL_GAP_CYCLES - 1)) begin
                    w_req_nxt   = 1'b1;
                    w_wr_nxt    = 1'b0;
                    w_addr_nxt  = A_SN_SSR;
                    w_wdata_nxt = 16'h0000;
                    w_state_nxt = S_POLL_RD;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + {{(GW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= 10'h000;
            r_wdata    <= 16'h0000;
            r_step     <= 4'd0;
            r_rst_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_poll_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_code     <= 2'd0;
            r_mac      <= 48'h0;
            r_ip       <= 32'h0;
            r_subnet   <= 32'h0;
            r_port     <= 16'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_wr       <= w_wr_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_step     <= w_step_nxt;
            r_rst_cnt  <= w_rst_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_poll_cnt <= w_poll_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_code     <= w_code_nxt;
            r_mac      <= w_mac_nxt;
            r_ip       <= w_ip_nxt;
            r_subnet   <= w_subnet_nxt;
            r_port     <= w_port_nxt;
        end
    end

endmodule
